// File: rtl/bitty_loader_pkg.sv
// Shared definitions for the bitty program loader: FSM state encoding,
// data widths and the length-byte interpretation.
package bitty_loader_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;

  // A length byte of zero requests a full-memory load.
  localparam bit LEN_ZERO_MEANS_FULL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_LO   = 3'd2,
    ST_HI   = 3'd3,
    ST_WR   = 3'd4,
    ST_CHK  = 3'd5,
    ST_DONE = 3'd6
  } state_t;

endpackage

// File: rtl/loader_checksum.sv
// 8-bit running sum over the load stream; the trailing check byte matches
// when it brings the accumulated sum to zero (two's-complement checksum).
module loader_checksum
  import bitty_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_clear,
  input  logic              i_add,
  input  logic [BYTE_W-1:0] i_byte,
  output logic              o_match
);

  logic [BYTE_W-1:0] r_sum;
  logic [BYTE_W-1:0] w_total;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sum <= '0;
    end else if (i_clear) begin
      r_sum <= '0;
    end else if (i_add) begin
      r_sum <= r_sum + i_byte;
    end
  end

  assign w_total = r_sum + i_byte;
  assign o_match = (w_total == '0);

endmodule

// File: rtl/bitty_program_loader.sv
// Byte-stream program loader for the bitty instruction memory.
// Optional trailing checksum byte is enabled with BITTY_LOADER_CHECKSUM_EN.
module bitty_program_loader
  import bitty_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              busy,
  output logic              load_done,
  output logic              core_run,
  output logic [ADDR_W:0]   words_loaded,
  output logic              error
);

  // Counter must hold both any length byte and the full-memory count.
  localparam int CNT_W = (ADDR_W + 1 > BYTE_W + 1) ? ADDR_W + 1 : BYTE_W + 1;
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(1) << ADDR_W;
  localparam logic [ADDR_W:0]   FULL_WL  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  state_t            r_state;
  logic [CNT_W-1:0]  r_n;
  logic [CNT_W-1:0]  r_cnt;
  logic [BYTE_W-1:0] r_lo;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [WORD_W-1:0] r_mem_wdata;
  logic              r_load_done;
  logic              r_core_run;

  logic              w_fire;
  logic              w_start_ok;
  logic [CNT_W-1:0]  w_len_n;
  logic [CNT_W-1:0]  w_cnt_inc;

  assign rx_ready   = (r_state == ST_LEN) || (r_state == ST_LO) ||
                      (r_state == ST_HI)  || (r_state == ST_CHK);
  assign busy       = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign w_fire     = rx_valid && rx_ready;
  assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_len_n    = (LEN_ZERO_MEANS_FULL && (rx_data == '0)) ? FULL_CNT : CNT_W'(rx_data);
  assign w_cnt_inc  = r_cnt + CNT_W'(1);

`ifdef BITTY_LOADER_CHECKSUM_EN
  logic r_error;
  logic w_chk_match;

  loader_checksum u_checksum (
    .clk     (clk),
    .reset   (reset),
    .i_clear (w_start_ok),
    .i_add   (w_fire && (r_state != ST_CHK)),
    .i_byte  (rx_data),
    .o_match (w_chk_match)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_error <= 1'b0;
    end else if (w_start_ok) begin
      r_error <= 1'b0;
    end else if ((r_state == ST_CHK) && w_fire) begin
      r_error <= !w_chk_match;
    end
  end

  assign error = r_error;
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_n         <= '0;
      r_cnt       <= '0;
      r_lo        <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= BASE;
      r_mem_wdata <= '0;
      r_load_done <= 1'b0;
      r_core_run  <= 1'b0;
    end else begin
      r_mem_we    <= 1'b0;
      r_load_done <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state    <= ST_LEN;
            r_core_run <= 1'b0;
            r_cnt      <= '0;
          end
        end
        ST_LEN: begin
          if (w_fire) begin
            r_n     <= w_len_n;
            r_cnt   <= '0;
            r_state <= ST_LO;
          end
        end
        ST_LO: begin
          if (w_fire) begin
            r_lo    <= rx_data;
            r_state <= ST_HI;
          end
        end
        ST_HI: begin
          // Address and data are registered here so they are stable for the whole WR cycle.
          if (w_fire) begin
            r_mem_wdata <= {rx_data, r_lo};
            r_mem_addr  <= BASE + r_cnt[ADDR_W-1:0];
            r_mem_we    <= 1'b1;
            r_state     <= ST_WR;
          end
        end
        ST_WR: begin
          r_cnt <= w_cnt_inc;
          if (w_cnt_inc == r_n) begin
`ifdef BITTY_LOADER_CHECKSUM_EN
            r_state <= ST_CHK;
`else
            r_state     <= ST_DONE;
            r_load_done <= 1'b1;
            r_core_run  <= 1'b1;
`endif
          end else begin
            r_state <= ST_LO;
          end
        end
`ifdef BITTY_LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (w_fire) begin
            r_state     <= ST_DONE;
            r_load_done <= 1'b1;
            r_core_run  <= w_chk_match;
          end
        end
`endif
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign load_done    = r_load_done;
  assign core_run     = r_core_run;
  assign words_loaded = (r_cnt >= FULL_CNT) ? FULL_WL : r_cnt[ADDR_W:0];

endmodule

// File: doc/bitty_program_loader.md
# bitty_program_loader

Writer-side counterpart to the instruction fetch path. It accepts a byte stream over a valid/ready handshake, assembles 16-bit instruction words, and writes them into the bitty instruction memory at consecutive addresses through the memory's write port. When the whole program is written it raises `core_run` so fetch and execution can start. It sits between the host byte link (UART receiver or testbench) and the shared instruction memory.

## Interface
- `ADDR_W`, 8, memory address width; 2^ADDR_W words.
- `BASE_ADDR`, 0, first word address written.
- `clk` in 1: single clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: single-cycle request to begin a load; ignored while `busy`.
- `rx_valid` in 1: byte on `rx_data` is valid.
- `rx_data` in 8: incoming byte.
- `rx_ready` out 1: loader can accept a byte this cycle.
- `mem_we` out 1: memory write strobe, one cycle per word.
- `mem_addr` out ADDR_W: write address.
- `mem_wdata` out 16: instruction word to write.
- `busy` out 1: load in progress (any state other than IDLE or DONE).
- `load_done` out 1: one-cycle pulse when the load completes.
- `core_run` out 1: level; program loaded and core released.
- `words_loaded` out ADDR_W+1: words written in the current or last load.
- `error` out 1: checksum mismatch on the last load, sticky until the next `start`.

## Operation
- Stream format: length byte L, then 2·N data bytes, low byte first. N = L, except L=0 means N = 2^ADDR_W.
- A byte transfers on a rising edge with `rx_valid && rx_ready`.
- States:
  - IDLE: `rx_ready`=0. `start` → LEN.
  - LEN: `rx_ready`=1. Byte → latch N, clear counter → LO.
  - LO: `rx_ready`=1. Byte → latch low byte → HI.
  - HI: `rx_ready`=1. Byte → latch high byte → WR.
  - WR: `rx_ready`=0, `mem_we`=1, `mem_addr`=(BASE_ADDR+index) mod 2^ADDR_W, counter++. If counter reaches N → CHK (macro) or DONE; otherwise → LO.
  - CHK: `rx_ready`=1. Byte compared → DONE.
  - DONE: `core_run`=1. `start` → LEN; `core_run` drops the same edge, `words_loaded` and `error` clear.
- `mem_addr` wraps modulo 2^ADDR_W. `words_loaded` saturates at 2^ADDR_W.
- `rx_valid` without `rx_ready` is ignored; the byte is not consumed.
- `start` in LEN/LO/HI/WR/CHK has no effect.
- Reset mid-load:
  - Return to IDLE next edge and discard the partial word.
  - Words already written remain in memory.

## Timing
- Reset values: `rx_ready`=0, `mem_we`=0, `mem_addr`=BASE_ADDR, `mem_wdata`=0, `busy`=0, `load_done`=0, `core_run`=0, `words_loaded`=0, `error`=0.
- `mem_we` and `mem_addr` are registered. The memory captures the write on the edge ending the WR cycle.
- Cycles per word: 3 with back-to-back valid bytes (LO, HI, WR). Minimum load: 2 + 3N cycles after `start` (one more with checksum).
- `load_done` pulses in the first DONE cycle. `core_run` rises in the same cycle and holds.
- Reset has priority over `start` and over a byte handshake in the same cycle.

## Configuration
- `BITTY_LOADER_CHECKSUM_EN` defined:
  - After the last word, expect one extra byte equal to the two's-complement of the 8-bit sum of L and all data bytes.
  - Mismatch sets `error`=1; `core_run` stays 0 in DONE.
  - Match gives `error`=0, `core_run`=1.
- Undefined:
  - CHK state absent; WR goes straight to DONE.
  - `error` tied 0.

## Structure
- Shared package `bitty_loader_pkg`: state encoding constants (IDLE, LEN, LO, HI, WR, CHK, DONE), byte and word widths, `LEN_ZERO_MEANS_FULL` constant.
- One sub-module `loader_checksum`: 8-bit accumulator with clear/add/compare, instantiated only under the macro.

## Test plan
- Load L=3, bytes 01 A0 02 B0 03 C0, back-to-back valid → writes A001@0, B002@1, C003@2; `load_done` pulse; `core_run`=1; `words_loaded`=3.
- Same stream with `rx_valid` toggling every other cycle → identical writes; no byte lost or duplicated.
- BASE_ADDR=254, L=4 → writes at 254, 255, 0, 1.
- L=0, ADDR_W=4 → 16 words written; `words_loaded`=16.
- Reset asserted in HI after 1.5 words → IDLE; no further `mem_we`; `core_run`=0; new `start` reloads cleanly.
- Macro on, L=1, bytes 34 12, checksum 0xB9 → `error`=0, `core_run`=1. Checksum 0x00 → `error`=1, `core_run`=0.
